// File: rtl/rect_mag_seq.sv
// rect_mag_seq
// Sequential rectangular-to-magnitude unit. Accepts an unsigned (x, y) pair,
// forms x*x + y*y with two 8-cycle shift-add passes into one 17-bit
// accumulator, then takes a 9-iteration restoring square root. Result is
// floor(sqrt(x*x + y*y)) plus a flag telling whether the sum is a perfect
// square. Latency is a fixed 25 enabled edges from accept to out_valid.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   ena        in   clock enable; low freezes every register
//   x, y       in   8-bit unsigned coordinates
//   in_valid   in   x/y offered
//   in_ready   out  block can accept (IDLE and enabled)
//   r          out  9-bit integer magnitude
//   exact      out  high when x*x + y*y is a perfect square
//   out_valid  out  r/exact valid, held until out_ready
//   out_ready  in   consumer takes the result
//   busy       out  high whenever not IDLE
module rect_mag_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] x,
  input  logic [7:0] y,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [8:0] r,
  output logic       exact,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SQX  = 3'd1,
    SQY  = 3'd2,
    ROOT = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  x_q, x_d;
  logic [7:0]  y_q, y_d;
  logic [16:0] acc_q, acc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [9:0]  rem_q, rem_d;
  logic [8:0]  root_q, root_d;
  logic [8:0]  r_q, r_d;
  logic        exact_q, exact_d;
  logic        outValid_q, outValid_d;

  // Square-root step datapath, evaluated every cycle and only committed in ROOT.
  logic [17:0] radPad;
  logic [4:0]  pairIdx;
  logic [1:0]  pair;
  logic [11:0] remShift;
  logic [11:0] trial;
  logic [11:0] remNext;
  logic [8:0]  rootNext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      rem_q      <= '0;
      root_q     <= '0;
      r_q        <= '0;
      exact_q    <= 1'b0;
      outValid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      root_q     <= root_d;
      r_q        <= r_d;
      exact_q    <= exact_d;
      outValid_q <= outValid_d;
    end
  end

  // The radicand is padded to 18 bits so it splits into 9 bit-pairs; the
  // pair for iteration cnt sits at bit 16 - 2*cnt (MSB pair first).
  always_comb begin
    radPad   = {1'b0, acc_q};
    pairIdx  = 5'd16 - {cnt_q, 1'b0};
    pair     = radPad[pairIdx +: 2];
    remShift = {rem_q, pair};
    trial    = {1'b0, root_q, 2'b01};
    if (remShift >= trial) begin
      remNext  = remShift - trial;
      rootNext = {root_q[7:0], 1'b1};
    end else begin
      remNext  = remShift;
      rootNext = {root_q[7:0], 1'b0};
    end
  end

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    root_d     = root_q;
    r_d        = r_q;
    exact_d    = exact_q;
    outValid_d = outValid_q;

    if (ena) begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            x_d     = x;
            y_d     = y;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = SQX;
          end
        end
        SQX: begin
          if (x_q[cnt_q[2:0]]) acc_d = acc_q + ({9'd0, x_q} << cnt_q[2:0]);
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            cnt_d   = '0;
            state_d = SQY;
          end
        end
        SQY: begin
          if (y_q[cnt_q[2:0]]) acc_d = acc_q + ({9'd0, y_q} << cnt_q[2:0]);
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            cnt_d   = '0;
            rem_d   = '0;
            root_d  = '0;
            state_d = ROOT;
          end
        end
        ROOT: begin
          rem_d  = remNext[9:0];
          root_d = rootNext;
          cnt_d  = cnt_q + 4'd1;
          if (cnt_q == 4'd8) begin
            cnt_d      = '0;
            r_d        = rootNext;
            exact_d    = (remNext == 12'd0);
            outValid_d = 1'b1;
            state_d    = DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            outValid_d = 1'b0;
            state_d    = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE) & ena;
  assign busy      = (state_q != IDLE);
  assign r         = r_q;
  assign exact     = exact_q;
  assign out_valid = outValid_q;

endmodule

// File: doc/rect_mag_seq.md
RECT_MAG_SEQ -- requirements
Module: rect_mag_seq

Interface
REQ-001 SHALL have port clk, input, 1, single system clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, reset; asynchronous and active-low.
REQ-003 SHALL have port ena, input, 1, when low the design holds every register, including state and counters.
REQ-004 SHALL have port x, input, 8, unsigned rectangular x coordinate.
REQ-005 SHALL have port y, input, 8, unsigned rectangular y coordinate.
REQ-006 SHALL have port in_valid, input, 1, x/y offered.
REQ-007 SHALL have port in_ready, output, 1, block can accept.
REQ-008 SHALL have port r, output, 9, floor(sqrt(x*x + y*y)).
REQ-009 SHALL have port exact, output, 1, high when x*x + y*y is a perfect square.
REQ-010 SHALL have port out_valid, output, 1, r/exact valid.
REQ-011 SHALL have port out_ready, input, 1, consumer takes the result.
REQ-012 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-013 SHALL implement the states IDLE, SQX, SQY, ROOT and DONE; in_ready = (state==IDLE) & ena, combinational.
REQ-014 Input handshake SHALL occur on a rising edge with in_valid & in_ready; x and y are captured into internal registers and the state goes IDLE->SQX.
REQ-015 SQX SHALL compute x*x into a 17-bit accumulator by 8-cycle shift-add (one multiplier bit per enabled edge); SQX->SQY on the 8th edge.
REQ-016 SQY SHALL add y*y to the same accumulator by 8-cycle shift-add; SQY->ROOT on the 8th edge; accumulator max 130050, with no overflow.
REQ-017 ROOT SHALL compute the digit-by-digit (restoring) square root of the 17-bit radicand, 9 iterations, one result bit per enabled edge, MSB first; ROOT->DONE on the 9th edge.
REQ-018 On entry to DONE, r SHALL be loaded with the 9-bit root, exact SHALL be loaded with (final remainder == 0), and out_valid SHALL go high.
REQ-019 Latency SHALL be exactly 25 enabled rising edges from the accepting edge to out_valid high, independent of data.
REQ-020 In DONE, r, exact and out_valid SHALL hold stable while out_ready is low (backpressure unlimited).
REQ-021 A rising edge in DONE with out_ready high SHALL clear out_valid and return to IDLE; in_ready becomes high only from the next cycle, so there is no same-edge accept/retire.
REQ-022 r and exact SHALL retain their last values after retirement until overwritten by the next DONE entry.
REQ-023 in_valid and x/y changes outside the accepting edge SHALL have no effect on an operation in progress.
REQ-024 When ena is low, no handshake SHALL occur (in_ready low), out_valid SHALL hold, and cycles with ena low SHALL not count toward latency.

Reset
REQ-025 On rst_n low, the design SHALL immediately (asynchronously) set state=IDLE, r=0, exact=0, out_valid=0, busy=0, and clear all accumulators and counters.
REQ-026 Reset asserted mid-operation SHALL abort the operation with no result produced; after release, the first accept starts a clean computation.
REQ-027 in_ready SHALL be high on the first cycle after rst_n deasserts if ena is high.

Verification
REQ-028 x=3, y=4, out_ready=1 -> out_valid high after the 25th edge after accept, r=5, exact=1, then IDLE.
REQ-029 x=255, y=255 -> r=360, exact=0; x=0, y=0 -> r=0, exact=1; x=7, y=24 -> r=25, exact=1; x=0, y=10 -> r=10.
REQ-030 x=5, y=12 with out_ready held low 40 cycles -> r=13, exact=1 stable throughout; in_ready stays low; retire on the first edge with out_ready high.
REQ-031 Start x=3, y=4, pulse rst_n low during ROOT -> all outputs 0 immediately; next op x=10, y=0 -> r=10 after exactly 25 edges.
REQ-032 Start x=3, y=4, drop ena for 7 cycles during SQY -> out_valid after 25+7 edges, r=5.
REQ-033 Change x/y and toggle in_valid while busy -> result matches the originally accepted x/y.
